inst_queue: RTL

INST_QUEUE -- requirements
Module: inst_queue

---
 rtl/enum_helpers.sv | 10 +
 rtl/struct_helpers.sv | 18 +
 rtl/inst_queue.sv | 91 +++++++++
 3 files changed

// File: rtl/enum_helpers.sv
// Shared enumerations for the fetch/decode front end.
//   control_signal_t : validity tag carried by each instruction slot.
package enum_helpers;

  typedef enum logic {
    INVALID = 1'b0,
    VALID   = 1'b1
  } control_signal_t;

endpackage

// File: rtl/struct_helpers.sv
// Shared structs for the fetch/decode front end.
//   Inst_PC   : one instruction slot (pc, instr, is_valid)
//   Inst_PC_N : a fetched pair, slot A then slot B
package struct_helpers;
  import enum_helpers::*;

  typedef struct packed {
    logic [31:0]     pc;
    logic [31:0]     instr;
    control_signal_t is_valid;
  } Inst_PC;

  typedef struct packed {
    Inst_PC A;
    Inst_PC B;
  } Inst_PC_N;

endpackage

// File: rtl/inst_queue.sv
// Instruction-pair queue between fetch and decode.
// A circular buffer of DEPTH instruction pairs. Pairs with neither half
// valid are dropped at the input. The head pair is read combinationally,
// so a pair pushed into an empty queue is visible the cycle after the push.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   flush        : discard all queued pairs (wins over push and pop)
//   in_valid     : fetch presents in_pair
//   in_pair      : fetched pair
//   in_ready     : queue not full
//   out_valid    : head pair available
//   out_pair     : head pair (all zero / INVALID when empty)
//   out_ready    : decode consumes the head pair
//   count        : number of occupied entries
module inst_queue
  import enum_helpers::*, struct_helpers::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  input  Inst_PC_N                   in_pair,
  output logic                       in_ready,
  output logic                       out_valid,
  output Inst_PC_N                   out_pair,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  Inst_PC_N           mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               is_bubble;
  logic               push;
  logic               pop;

  // Status depends on registered count only, so a pop in the same cycle
  // never opens room for a push.
  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);

  assign is_bubble = (in_pair.A.is_valid != VALID) && (in_pair.B.is_valid != VALID);
  assign push      = in_valid && in_ready && !flush && !is_bubble;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    out_pair = '0;
    if (out_valid) begin
      out_pair = mem[rd_ptr];
    end
  end

  // Storage is data only and is never cleared; validity comes from count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_pair;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
